// File: rtl/noc_pkg.sv
// Shared NoC definitions: port indices, credit width and the allocator state encoding.
// Helper wrap_add performs modulo-NUM_PORTS index arithmetic for the arbiters.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int CRED_W = 3;
  localparam logic [2:0] SEL_NONE = 3'd7;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BLOCKED
  } alloc_state_e;

  typedef logic [CRED_W-1:0] credit_t;

  // Both operands are port indices (0..4), so one conditional subtract suffices.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping over the ports.
module rr_pick
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [2:0]           ptr,
  output logic                 valid,
  output logic [2:0]           winner
);

  logic [2:0] idx;

  // Scan from the farthest offset down so the nearest requester is assigned last and wins.
  always_comb begin
    valid  = 1'b0;
    winner = 3'd0;
    idx    = 3'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = wrap_add(ptr, 3'(i));
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/port_allocator.sv
// Credit-based output-port allocator with round-robin arbitration over the five input ports.
// Optional macro PORT_ALLOC_STATS_EN adds a 16-bit wrapping grant counter output grant_cnt_o.
module port_allocator
  import noc_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 credit_inc_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [2:0]           port_sel_o,
  output logic                 send_en_o,
  output logic [CRED_W-1:0]    credits_o,
  output logic                 full_o,
  output logic                 ovf_err_o
`ifdef PORT_ALLOC_STATS_EN
  ,
  output logic [15:0]          grant_cnt_o
`endif
);

  localparam credit_t CREDIT_MAX = credit_t'(CREDITS);

  alloc_state_e state, next_state;
  logic [2:0] ptr;
  credit_t    credits;
  logic       ovf_err;
  logic       pick_valid;
  logic [2:0] pick_idx;
  logic       load;
  logic       in_grant;

  rr_pick u_pick (
    .req    (req_i),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign in_grant = (state == ST_GRANT);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (pick_valid) next_state = (credits != '0) ? ST_GRANT : ST_BLOCKED;
      end
      ST_GRANT: next_state = ST_IDLE;
      ST_BLOCKED: begin
        if (credits != '0) next_state = pick_valid ? ST_GRANT : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    load = (next_state == ST_GRANT) && (state != ST_GRANT);
  end

  // Grant outputs are registered alongside the state so they line up with the GRANT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= 3'd0;
      grant_o    <= '0;
      port_sel_o <= SEL_NONE;
    end else begin
      state <= next_state;
      if (load) begin
        ptr        <= wrap_add(pick_idx, 3'd1);
        grant_o    <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
        port_sel_o <= pick_idx;
      end else begin
        grant_o    <= '0;
        port_sel_o <= SEL_NONE;
      end
    end
  end

  // A returned credit and a consumed one in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CREDIT_MAX;
      ovf_err <= 1'b0;
    end else begin
      case ({in_grant, credit_inc_i})
        2'b01: begin
          if (credits == CREDIT_MAX) ovf_err <= 1'b1;
          else credits <= credits + credit_t'(1);
        end
        2'b10: credits <= credits - credit_t'(1);
        default: ;
      endcase
    end
  end

`ifdef PORT_ALLOC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) grant_cnt_o <= 16'd0;
    else if (in_grant) grant_cnt_o <= grant_cnt_o + 16'd1;
  end
`endif

  assign send_en_o = |grant_o;
  assign credits_o = credits;
  assign full_o    = (credits == '0);
  assign ovf_err_o = ovf_err;

endmodule

// File: tb/tb_port_allocator.sv
// Scoreboard bench for port_allocator: a driver feeds directed and random traffic through a
// reference model that queues expected grants; a negedge monitor pops and compares them.
module tb_port_allocator;
  import noc_pkg::*;

  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_i;
  logic        credit_inc_i;
  logic [4:0]  grant_o;
  logic [2:0]  port_sel_o;
  logic        send_en_o;
  logic [2:0]  credits_o;
  logic        full_o;
  logic        ovf_err_o;
`ifdef PORT_ALLOC_STATS_EN
  logic [15:0] grant_cnt_o;
`endif

  port_allocator #(.CREDITS(CREDITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .credit_inc_i (credit_inc_i),
    .grant_o      (grant_o),
    .port_sel_o   (port_sel_o),
    .send_en_o    (send_en_o),
    .credits_o    (credits_o),
    .full_o       (full_o),
    .ovf_err_o    (ovf_err_o)
`ifdef PORT_ALLOC_STATS_EN
    ,
    .grant_cnt_o  (grant_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int port;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   sel_log[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   grants_seen = 0;

  // Reference model: a grant appears one cycle after any request is seen with credit,
  // unless the allocator is already presenting a grant that cycle.
  int   m_credits;
  int   m_ptr;
  bit   m_grant;
  bit   m_ovf;
  int   m_stat;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void model_reset();
    m_credits = CREDITS;
    m_ptr     = 0;
    m_grant   = 1'b0;
    m_ovf     = 1'b0;
    m_stat    = 0;
    exp_q.delete();
  endfunction

  task automatic apply_stimulus(input logic [4:0] req, input logic inc);
    bit grant_now;
    int winner;
    req_i        = req;
    credit_inc_i = inc;
    grant_now    = m_grant;
    m_grant      = 1'b0;
    if (!grant_now && req != 5'd0 && m_credits > 0) begin
      winner = -1;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (winner < 0 && ((req >> ((m_ptr + k) % NUM_PORTS)) & 5'd1) != 5'd0)
          winner = (m_ptr + k) % NUM_PORTS;
      end
      exp_q.push_back('{port: winner, cyc: cyc + 1});
      m_ptr   = (winner + 1) % NUM_PORTS;
      m_grant = 1'b1;
    end
    if (grant_now) m_stat = (m_stat + 1) % 65536;
    if (inc && !grant_now) begin
      if (m_credits == CREDITS) m_ovf = 1'b1;
      else m_credits++;
    end else if (!inc && grant_now) begin
      m_credits--;
    end
    @(posedge clk);
    cyc++;
    #2;
    check_output("credits", int'(credits_o), m_credits);
    check_output("full", int'(full_o), (m_credits == 0) ? 1 : 0);
    check_output("ovf_err", int'(ovf_err_o), m_ovf ? 1 : 0);
  endtask

  // Reset takes effect without a clock edge, so outputs are checked 1ns after assertion.
  task automatic apply_reset();
    rst          = 1'b1;
    req_i        = 5'd0;
    credit_inc_i = 1'b0;
    #1;
    check_output("rst_grant", int'(grant_o), 0);
    check_output("rst_send_en", int'(send_en_o), 0);
    check_output("rst_port_sel", int'(port_sel_o), 7);
    check_output("rst_credits", int'(credits_o), CREDITS);
    check_output("rst_full", int'(full_o), 0);
    check_output("rst_ovf", int'(ovf_err_o), 0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (send_en_o) begin
        grants_seen++;
        sel_log.push_back(int'(port_sel_o));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_grant: got port_sel %0d, expected no grant (cycle %0d)",
                   port_sel_o, cyc);
        end else begin
          e = exp_q.pop_front();
          check_output("grant_port", int'(port_sel_o), e.port);
          check_output("grant_onehot", int'(grant_o), 1 << e.port);
          check_output("grant_cycle", cyc, e.cyc);
        end
      end else begin
        check_output("idle_outputs", int'({grant_o, port_sel_o}), 7);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("[TB] FAIL missing_grant: got no grant, expected port %0d (cycle %0d)",
                   e.port, cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g0;
    rst          = 1'b1;
    req_i        = 5'd0;
    credit_inc_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    apply_reset();

    // Reset then idle.
    repeat (10) apply_stimulus(5'd0, 1'b0);

    // Round-robin order with all ports requesting and credit returned each grant.
    sel_log.delete();
    for (int i = 0; i < 12; i++) apply_stimulus(5'b11111, m_grant);
    apply_stimulus(5'd0, m_grant);
    check_output("rr_count", sel_log.size(), 6);
    for (int i = 0; i < 6 && i < sel_log.size(); i++) check_output("rr_order", sel_log[i], i % 5);

    // Credit exhaustion on E, then a single returned credit.
    g0 = grants_seen;
    repeat (12) apply_stimulus(5'b00100, 1'b0);
    check_output("exhaust_grants", grants_seen - g0, 4);
    check_output("exhaust_full", int'(full_o), 1);
    g0 = grants_seen;
    apply_stimulus(5'b00100, 1'b1);
    repeat (6) apply_stimulus(5'b00100, 1'b0);
    check_output("one_more_grant", grants_seen - g0, 1);

    // Grant and credit return together at two credits.
    apply_reset();
    repeat (5) apply_stimulus(5'b00001, 1'b0);
    apply_stimulus(5'b00001, 1'b1);
    check_output("simul_credits", int'(credits_o), 2);
    apply_stimulus(5'd0, 1'b0);

    // Overflow: returns past full capacity set a sticky error.
    repeat (3) apply_stimulus(5'd0, 1'b1);
    check_output("ovf_set", int'(ovf_err_o), 1);
    repeat (3) apply_stimulus(5'd0, 1'b0);
    check_output("ovf_sticky", int'(ovf_err_o), 1);

    // Reset landing in the GRANT cycle cancels it and rewinds the pointer.
    apply_stimulus(5'b00010, 1'b0);
    apply_reset();
    sel_log.delete();
    apply_stimulus(5'b11111, 1'b0);
    apply_stimulus(5'd0, 1'b0);
    check_output("post_rst_count", sel_log.size(), 1);
    if (sel_log.size() > 0) check_output("post_rst_winner", sel_log[0], 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r;
      logic c;
      r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      c = ($urandom_range(0, 2) == 0);
      apply_stimulus(r, c);
    end
    repeat (3) apply_stimulus(5'd0, 1'b0);

    check_output("scoreboard_drained", exp_q.size(), 0);
`ifdef PORT_ALLOC_STATS_EN
    check_output("grant_cnt", int'(grant_cnt_o), m_stat);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
